// File: rtl/cf_fft_bfly_param.sv
// Radix-2 DIT FFT butterfly: P = A + W*B, M = A - W*B, with a half-circle twiddle ROM,
// 4-stage clock-enabled pipeline, per-sample inverse/scale, rounding and saturation options.
module cf_fft_bfly_param #(
  parameter int DW     = 8,
  parameter int TW     = 8,
  parameter int ADDR_W = 7,
  parameter int ROUND  = 0,
  parameter int SAT    = 1
) (
  input  logic                clock_c,
  input  logic                reset_n,
  input  logic                ce,
  input  logic                in_valid,
  input  logic [2*DW-1:0]     in_a,
  input  logic [2*DW-1:0]     in_b,
  input  logic [ADDR_W-1:0]   in_k,
  input  logic                in_inv,
  input  logic                in_scale,
  input  logic                clr_ovf,
  output logic                out_valid,
  output logic [2*DW-1:0]     out_p,
  output logic [2*DW-1:0]     out_m,
  output logic                ovf
);

  localparam int  N    = 1 << ADDR_W;
  localparam int  PW   = DW + TW;
  localparam int  SW   = DW + 2;
  localparam int  AW   = DW + 3;
  localparam int  MAXW = (1 << (TW - 1)) - 1;
  localparam int  RND3 = (ROUND != 0) ? (1 << (TW - 2)) : 0;
  localparam int  RND4 = (ROUND != 0) ? 1 : 0;
  localparam real PI   = 3.14159265358979323846;

  localparam logic signed [TW-1:0] W_MIN  = {1'b1, {(TW-1){1'b0}}};
  localparam logic signed [TW-1:0] W_MAX  = ~W_MIN;
  localparam logic signed [AW-1:0] LIM_HI = AW'((1 << (DW - 1)) - 1);
  localparam logic signed [AW-1:0] LIM_LO = AW'(-(1 << (DW - 1)));

  function automatic int tw_val(input int k, input bit im);
    real ang;
    real v;
    int  r;
    ang = PI * real'(k) / real'(N);
    v   = im ? -real'(1 << (TW - 1)) * $sin(ang) : real'(1 << (TW - 1)) * $cos(ang);
    r   = $rtoi($floor(v));
    if (r > MAXW) r = MAXW;
    return r;
  endfunction

  logic signed [TW-1:0] rom_re [N];
  logic signed [TW-1:0] rom_im [N];

  for (genvar g = 0; g < N; g++) begin : g_rom
    localparam int RE = tw_val(g, 1'b0);
    localparam int IM = tw_val(g, 1'b1);
    assign rom_re[g] = TW'(RE);
    assign rom_im[g] = TW'(IM);
  end

  // Conjugate for inverse; -(-full scale) cannot be represented, so clamp it.
  logic signed [TW-1:0] w_re, w_im;
  always_comb begin
    w_re = rom_re[in_k];
    w_im = rom_im[in_k];
    if (in_inv) w_im = (w_im == W_MIN) ? W_MAX : -w_im;
  end

  logic                 s1_valid, s1_scale;
  logic signed [DW-1:0] s1_are, s1_aim, s1_bre, s1_bim;
  logic signed [TW-1:0] s1_wre, s1_wim;

  always_ff @(posedge clock_c or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_scale <= 1'b0;
      s1_are   <= '0;
      s1_aim   <= '0;
      s1_bre   <= '0;
      s1_bim   <= '0;
      s1_wre   <= '0;
      s1_wim   <= '0;
    end else if (ce) begin
      s1_valid <= in_valid;
      s1_scale <= in_scale;
      s1_are   <= in_a[2*DW-1:DW];
      s1_aim   <= in_a[DW-1:0];
      s1_bre   <= in_b[2*DW-1:DW];
      s1_bim   <= in_b[DW-1:0];
      s1_wre   <= w_re;
      s1_wim   <= w_im;
    end
  end

  logic                 s2_valid, s2_scale;
  logic signed [DW-1:0] s2_are, s2_aim;
  logic signed [PW-1:0] s2_rr, s2_ii, s2_ri, s2_ir;

  always_ff @(posedge clock_c or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid <= 1'b0;
      s2_scale <= 1'b0;
      s2_are   <= '0;
      s2_aim   <= '0;
      s2_rr    <= '0;
      s2_ii    <= '0;
      s2_ri    <= '0;
      s2_ir    <= '0;
    end else if (ce) begin
      s2_valid <= s1_valid;
      s2_scale <= s1_scale;
      s2_are   <= s1_are;
      s2_aim   <= s1_aim;
      s2_rr    <= PW'(s1_bre) * PW'(s1_wre);
      s2_ii    <= PW'(s1_bim) * PW'(s1_wim);
      s2_ri    <= PW'(s1_bre) * PW'(s1_wim);
      s2_ir    <= PW'(s1_bim) * PW'(s1_wre);
    end
  end

  // Rounding bias is folded into the combine so the shift back to Q0 is a plain >>>.
  logic signed [PW:0] re_full, im_full;
  always_comb begin
    re_full = (PW+1)'(s2_rr) - (PW+1)'(s2_ii) + (PW+1)'(RND3);
    im_full = (PW+1)'(s2_ri) + (PW+1)'(s2_ir) + (PW+1)'(RND3);
  end

  logic                 s3_valid, s3_scale;
  logic signed [DW-1:0] s3_are, s3_aim;
  logic signed [SW-1:0] s3_wbre, s3_wbim;

  always_ff @(posedge clock_c or negedge reset_n) begin
    if (!reset_n) begin
      s3_valid <= 1'b0;
      s3_scale <= 1'b0;
      s3_are   <= '0;
      s3_aim   <= '0;
      s3_wbre  <= '0;
      s3_wbim  <= '0;
    end else if (ce) begin
      s3_valid <= s2_valid;
      s3_scale <= s2_scale;
      s3_are   <= s2_are;
      s3_aim   <= s2_aim;
      s3_wbre  <= SW'(re_full >>> (TW - 1));
      s3_wbim  <= SW'(im_full >>> (TW - 1));
    end
  end

  logic signed [AW-1:0] sum [4];
  logic signed [AW-1:0] adj [4];
  logic        [DW-1:0] red [4];
  logic        [3:0]    comp_ovf;

  always_comb begin
    sum[0] = AW'(s3_are) + AW'(s3_wbre);
    sum[1] = AW'(s3_aim) + AW'(s3_wbim);
    sum[2] = AW'(s3_are) - AW'(s3_wbre);
    sum[3] = AW'(s3_aim) - AW'(s3_wbim);
    for (int i = 0; i < 4; i++) begin
      adj[i]      = s3_scale ? ((sum[i] + AW'(RND4)) >>> 1) : sum[i];
      comp_ovf[i] = (adj[i] > LIM_HI) || (adj[i] < LIM_LO);
      if ((SAT != 0) && comp_ovf[i])
        red[i] = adj[i][AW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      else
        red[i] = adj[i][DW-1:0];
    end
  end

  logic ovf_event;
  assign ovf_event = ce && s3_valid && (|comp_ovf);

  always_ff @(posedge clock_c or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_p     <= '0;
      out_m     <= '0;
    end else if (ce) begin
      out_valid <= s3_valid;
      out_p     <= {red[0], red[1]};
      out_m     <= {red[2], red[3]};
    end
  end

  // Sticky flag: clear ignores ce, and a same-edge overflow wins over the clear.
  always_ff @(posedge clock_c or negedge reset_n) begin
    if (!reset_n)       ovf <= 1'b0;
    else if (ovf_event) ovf <= 1'b1;
    else if (clr_ovf)   ovf <= 1'b0;
  end

endmodule
